// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues word fetches at fetch_pc, tracks in-flight requests and buffers
// returned {instr, pc} pairs in order for decode. A flush squashes queued and in-flight fetches.
module ifetch_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   pc_fifo [DEPTH];
  logic [PW-1:0] q_head, q_tail, pf_head, pf_tail;
  logic [CW-1:0] occ, outst, drop;
  logic          req_ok, accept, resp, keep, pop;

  // Handshakes: a request transfers when imem_req & imem_gnt in the same cycle; a response is
  // one imem_rvalid cycle, in request order; decode takes the head when if_valid & id_ready.
  assign req_ok     = reset && ((occ + outst) < DEPTH_C) && !flush && !misalign_err;
  assign imem_req   = req_ok && (fetch_pc[1:0] == 2'b00);
  assign imem_addr  = fetch_pc;
  assign pc_advance = imem_req && imem_gnt;
  assign accept     = pc_advance;
  assign resp       = imem_rvalid && (outst != '0);
  assign keep       = resp && (drop == '0) && !flush;
  assign if_valid   = (occ != '0);
  assign pop        = if_valid && id_ready;
  assign if_instr   = if_valid ? q_instr[q_head] : NOP_INSTR;
  assign if_pc      = if_valid ? q_pc[q_head] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_head       <= '0;
      q_tail       <= '0;
      pf_head      <= '0;
      pf_tail      <= '0;
      occ          <= '0;
      outst        <= '0;
      drop         <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (accept) pf_tail <= pf_tail + P_ONE;
      if (resp)   pf_head <= pf_head + P_ONE;
      outst <= outst + (accept ? C_ONE : '0) - (resp ? C_ONE : '0);
      if (req_ok && (fetch_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
      // No accept can happen while flushing, so only a response reduces what is still owed.
      if (flush) begin
        q_head <= '0;
        q_tail <= '0;
        occ    <= '0;
        drop   <= outst - (resp ? C_ONE : '0);
      end else begin
        if (keep) q_tail <= q_tail + P_ONE;
        if (pop)  q_head <= q_head + P_ONE;
        occ <= occ + (keep ? C_ONE : '0) - (pop ? C_ONE : '0);
        if (resp && (drop != '0)) drop <= drop - C_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      q_instr[q_tail] <= imem_rdata;
      q_pc[q_tail]    <= pc_fifo[pf_head];
    end
    if (accept) pc_fifo[pf_tail] <= fetch_pc;
  end

  rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (!reset) !(imem_rvalid && (outst == '0)));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-based reference model checked every cycle, a latency-programmable
// instruction memory, and directed scenarios with hand-computed expectations.
module tb_ifetch_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pc_advance;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  ifetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready), .misalign_err(misalign_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected queue of {instr, pc}, plus in-flight PCs and counters
  logic [63:0] exp_q[$];
  logic [31:0] m_pcs[$];
  int          m_out = 0;
  int          m_drop = 0;
  bit          m_err = 1'b0;
  bit          e_valid, credit, e_req;
  logic [31:0] rpc;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_if_instr", if_instr, NOP);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_pc_advance", 32'(pc_advance), 32'd0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      exp_q.delete();
      m_pcs.delete();
      m_out = 0;
      m_drop = 0;
      m_err = 1'b0;
    end else begin
      e_valid = (exp_q.size() != 0);
      credit  = (exp_q.size() + m_out) < DEPTH;
      e_req   = credit && !flush && !m_err && (fetch_pc[1:0] == 2'b00);
      check("if_valid", 32'(if_valid), 32'(e_valid));
      check("if_instr", if_instr, e_valid ? exp_q[0][63:32] : NOP);
      check("if_pc", if_pc, e_valid ? exp_q[0][31:0] : 32'd0);
      check("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) check("imem_addr", imem_addr, fetch_pc);
      check("pc_advance", 32'(pc_advance), 32'(e_req && imem_gnt));
      check("misalign_err", 32'(misalign_err), 32'(m_err));
      if (credit && !flush && !m_err && (fetch_pc[1:0] != 2'b00)) m_err = 1'b1;
      if (e_valid && id_ready) void'(exp_q.pop_front());
      if (imem_rvalid && (m_out > 0)) begin
        rpc = m_pcs.pop_front();
        m_out--;
        if (m_drop > 0) m_drop--;
        else if (!flush) exp_q.push_back({instr_of(rpc), rpc});
      end
      if (e_req && imem_gnt) begin
        m_pcs.push_back(fetch_pc);
        m_out++;
      end
      if (flush) begin
        exp_q.delete();
        m_drop = m_out;
      end
    end
  end

  // memory and PC-unit stand-in
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          lat = 1;

  task automatic step();
    bit acc;
    @(negedge clk);
    acc = imem_req && imem_gnt;
    if (acc) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) fetch_pc = fetch_pc + 32'd4;
    flush = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if ((pend_due.size() != 0) && (pend_due[0] <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata = instr_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic start(input logic [31:0] pc, input logic gnt, input logic rdy, input int l);
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    imem_gnt = 1'b0;
    id_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    fetch_pc = pc;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    imem_gnt = gnt;
    id_ready = rdy;
    lat = l;
    cyc = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_instr"}, if_instr, 32'h00000013);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    check({tag, "_pc_advance"}, 32'(pc_advance), 32'd0);
    check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    #1;
    check_reset_outs("t1_reset");

    // 1: streaming from PC 0 with a 1-cycle memory
    start(32'h0, 1'b1, 1'b1, 1);
    #1;
    check("t1_c0_req", 32'(imem_req), 32'd1);
    check("t1_c0_addr", imem_addr, 32'h0);
    step();
    step();
    #1;
    check("t1_c2_valid", 32'(if_valid), 32'd1);
    check("t1_c2_pc", if_pc, 32'h0);
    check("t1_c2_instr", if_instr, 32'hA0000000);
    step();
    #1;
    check("t1_c3_pc", if_pc, 32'h4);
    check("t1_c3_instr", if_instr, 32'hA0000004);
    check("t1_c3_req", 32'(imem_req), 32'd1);
    repeat (12) step();

    // 2: decode stalled, queue fills, then drains in order
    start(32'h100, 1'b1, 1'b0, 1);
    repeat (3) step();
    #1;
    check("t2_c3_req", 32'(imem_req), 32'd0);
    check("t2_c3_adv", 32'(pc_advance), 32'd0);
    check("t2_c3_pc", if_pc, 32'h100);
    step();
    #1;
    check("t2_c4_pc", if_pc, 32'h100);
    id_ready = 1'b1;
    step();
    #1;
    check("t2_c5_pc", if_pc, 32'h104);
    check("t2_c5_instr", if_instr, 32'hA0000104);
    step();
    #1;
    check("t2_c6_valid", 32'(if_valid), 32'd0);
    step();
    #1;
    check("t2_c7_pc", if_pc, 32'h108);
    repeat (4) step();

    // 3: flush with two fetches in flight on a 3-cycle memory
    start(32'h0, 1'b1, 1'b1, 3);
    step();
    step();
    flush = 1'b1;
    fetch_pc = 32'h40;
    #1;
    check("t3_flush_req", 32'(imem_req), 32'd0);
    step();
    #1;
    check("t3_c3_valid", 32'(if_valid), 32'd0);
    check("t3_c3_req", 32'(imem_req), 32'd0);
    step();
    #1;
    check("t3_c4_req", 32'(imem_req), 32'd1);
    check("t3_c4_addr", imem_addr, 32'h40);
    check("t3_c4_valid", 32'(if_valid), 32'd0);
    for (int i = 5; i <= 7; i++) begin
      step();
      #1;
      check("t3_quiet_valid", 32'(if_valid), 32'd0);
    end
    step();
    #1;
    check("t3_c8_valid", 32'(if_valid), 32'd1);
    check("t3_c8_pc", if_pc, 32'h40);
    check("t3_c8_instr", if_instr, 32'hA0000040);
    repeat (6) step();

    // 4: flush coinciding with a response and a pop
    start(32'h200, 1'b1, 1'b1, 1);
    step();
    step();
    #1;
    check("t4_c2_pc", if_pc, 32'h200);
    check("t4_c2_rvalid_in", 32'(imem_rvalid), 32'd1);
    flush = 1'b1;
    fetch_pc = 32'h300;
    #1;
    check("t4_flush_req", 32'(imem_req), 32'd0);
    step();
    #1;
    check("t4_c3_valid", 32'(if_valid), 32'd0);
    check("t4_c3_instr", if_instr, 32'h00000013);
    check("t4_c3_req", 32'(imem_req), 32'd1);
    check("t4_c3_addr", imem_addr, 32'h300);
    step();
    #1;
    check("t4_c4_valid", 32'(if_valid), 32'd0);
    step();
    #1;
    check("t4_c5_pc", if_pc, 32'h300);
    check("t4_c5_instr", if_instr, 32'hA0000300);
    repeat (4) step();

    // 5: misaligned PC blocks requests until reset
    start(32'h6, 1'b1, 1'b1, 1);
    #1;
    check("t5_c0_req", 32'(imem_req), 32'd0);
    check("t5_c0_err", 32'(misalign_err), 32'd0);
    step();
    #1;
    check("t5_c1_err", 32'(misalign_err), 32'd1);
    fetch_pc = 32'h8;
    #1;
    check("t5_aligned_req", 32'(imem_req), 32'd0);
    repeat (2) step();
    #1;
    check("t5_c3_err", 32'(misalign_err), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_err", 32'(misalign_err), 32'd0);

    // 6: asynchronous reset mid-stream, between clock edges
    start(32'h1000, 1'b1, 1'b1, 1);
    repeat (3) step();
    #1;
    check("t6_pre_valid", 32'(if_valid), 32'd1);
    check("t6_pre_pc", if_pc, 32'h1004);
    check("t6_pre_req", 32'(imem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outs("t6_async");

    // 7: flush while credit is available suppresses the request
    start(32'h500, 1'b1, 1'b1, 1);
    flush = 1'b1;
    #1;
    check("t7_flush_req", 32'(imem_req), 32'd0);
    check("t7_flush_adv", 32'(pc_advance), 32'd0);
    step();
    #1;
    check("t7_c1_req", 32'(imem_req), 32'd1);
    check("t7_c1_addr", imem_addr, 32'h500);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
